// File: rtl/mema_row_loader.sv
// Assembles DIM-element A rows from a word stream, writes them into memA, then drives memA's
// shift enable for the skewed-drain window. Optional abort input: define MEMA_LDR_ABORT_EN.
module mema_row_loader #(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8,
   parameter int WORD_W  = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             load,
   input  logic                             start,
`ifdef MEMA_LDR_ABORT_EN
   input  logic                             abort,
`endif
   input  logic                             wr_valid,
   output logic                             wr_ready,
   input  logic [WORD_W-1:0]                wr_data,
   output logic                             WrEn,
   output logic [$clog2(DIM)-1:0]           Arow,
   output logic [DIM-1:0][BITS_AB-1:0]      Ain,
   output logic                             en,
   output logic                             loaded,
   output logic                             busy,
   output logic                             done
);

   localparam int WPR   = DIM * BITS_AB / WORD_W;
   localparam int DRAIN = 3 * DIM - 2;
   localparam int ROW_W = DIM * BITS_AB;
   localparam int WCW   = (WPR > 1) ? $clog2(WPR) : 1;
   localparam int RCW   = $clog2(DIM);
   localparam int SCW   = $clog2(DRAIN + 1);

   typedef enum logic [2:0] {IDLE, LOAD, COMMIT, READY, STREAM} state_t;

   state_t             state_q, state_d;
   logic [WCW-1:0]     word_cnt_q, word_cnt_d;
   logic [RCW-1:0]     row_cnt_q, row_cnt_d;
   logic [SCW-1:0]     strm_cnt_q, strm_cnt_d;
   logic [ROW_W-1:0]   row_buf_q, row_buf_d;
   logic [ROW_W-1:0]   ain_q, ain_d;
   logic               wr_en_q, wr_en_d;
   logic               en_q, en_d;
   logic               done_q, done_d;

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      row_cnt_d  = row_cnt_q;
      strm_cnt_d = strm_cnt_q;
      row_buf_d  = row_buf_q;
      ain_d      = ain_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d    = LOAD;
               word_cnt_d = '0;
               row_cnt_d  = '0;
            end
         end
         LOAD: begin
            if (wr_valid) begin
               row_buf_d[int'(word_cnt_q)*WORD_W +: WORD_W] = wr_data;
               if (word_cnt_q == WCW'(WPR - 1)) begin
                  // Capture the completed row so Ain is stable throughout COMMIT
                  ain_d      = row_buf_d;
                  word_cnt_d = '0;
                  state_d    = COMMIT;
               end else begin
                  word_cnt_d = word_cnt_q + WCW'(1);
               end
            end
         end
         COMMIT: begin
            if (row_cnt_q == RCW'(DIM - 1)) begin
               state_d = READY;
            end else begin
               row_cnt_d = row_cnt_q + RCW'(1);
               state_d   = LOAD;
            end
         end
         READY: begin
            if (start) begin
               strm_cnt_d = '0;
               state_d    = STREAM;
            end
         end
         STREAM: begin
            if (strm_cnt_q == SCW'(DRAIN - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               strm_cnt_d = strm_cnt_q + SCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef MEMA_LDR_ABORT_EN
      if (abort) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
`endif
      // Strobes are registered off the next state so they align with the state they belong to
      wr_en_d = (state_d == COMMIT);
      en_d    = (state_d == STREAM);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         word_cnt_q <= '0;
         row_cnt_q  <= '0;
         strm_cnt_q <= '0;
         row_buf_q  <= '0;
         ain_q      <= '0;
         wr_en_q    <= 1'b0;
         en_q       <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         row_cnt_q  <= row_cnt_d;
         strm_cnt_q <= strm_cnt_d;
         row_buf_q  <= row_buf_d;
         ain_q      <= ain_d;
         wr_en_q    <= wr_en_d;
         en_q       <= en_d;
         done_q     <= done_d;
      end
   end

   assign wr_ready = (state_q == LOAD);
   assign loaded   = (state_q == READY);
   assign busy     = (state_q != IDLE);
   assign WrEn     = wr_en_q;
   assign en       = en_q;
   assign done     = done_q;
   assign Arow     = row_cnt_q;
   assign Ain      = ain_q;

endmodule

// File: tb/tb_mema_row_loader.sv
// Randomized scoreboard bench for mema_row_loader: expected rows and drain lengths are queued by
// the stimulus, and a negedge monitor pops them whenever WrEn or done appears.
module tb_mema_row_loader;

   localparam int BITS_AB = 8;
   localparam int DIM     = 8;
   localparam int WORD_W  = 32;
   localparam int EPW     = WORD_W / BITS_AB;
   localparam int WPR     = DIM * BITS_AB / WORD_W;
   localparam int NW      = DIM * WPR;
   localparam int DRAIN   = 3 * DIM - 2;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic                        load = 1'b0;
   logic                        start = 1'b0;
   logic                        wr_valid = 1'b0;
   logic                        wr_ready;
   logic [WORD_W-1:0]           wr_data = '0;
   logic                        WrEn;
   logic [$clog2(DIM)-1:0]      Arow;
   logic [DIM-1:0][BITS_AB-1:0] Ain;
   logic                        en, loaded, busy, done;
`ifdef MEMA_LDR_ABORT_EN
   logic                        abort = 1'b0;
`endif

   always #5 clk = ~clk;

   mema_row_loader #(.BITS_AB(BITS_AB), .DIM(DIM), .WORD_W(WORD_W)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .start(start),
`ifdef MEMA_LDR_ABORT_EN
      .abort(abort),
`endif
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .WrEn(WrEn), .Arow(Arow), .Ain(Ain), .en(en),
      .loaded(loaded), .busy(busy), .done(done)
   );

   typedef struct {
      int                          row;
      logic [DIM-1:0][BITS_AB-1:0] data;
   } row_t;

   int   vectors = 0;
   int   miscompares = 0;
   row_t exp_rows[$];
   int   exp_runs[$];
   int   en_run = 0;
   int   done_cnt = 0;
   logic [WORD_W-1:0] words [NW];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: row r element e is byte (e mod EPW) of word r*WPR + e/EPW of the matrix stream
   task automatic push_rows();
      row_t        r;
      logic [WORD_W-1:0] w;
      for (int ri = 0; ri < DIM; ri++) begin
         r.row = ri;
         for (int e = 0; e < DIM; e++) begin
            w = words[ri*WPR + e/EPW];
            r.data[e] = w[(e%EPW)*BITS_AB +: BITS_AB];
         end
         exp_rows.push_back(r);
      end
   endtask

   // Monitor: sampled on negedge, away from the active edge
   always @(negedge clk) begin
      if (!rst_n) begin
         en_run = 0;
      end else begin
         if (WrEn || en || done)
            check("one_strobe", 64'(int'(WrEn) + int'(en) + int'(done)), 64'd1);
         if (WrEn) begin
            if (exp_rows.size() == 0) begin
               check("unexpected_wren", 64'd1, 64'd0);
            end else begin
               row_t r;
               r = exp_rows.pop_front();
               check("arow", 64'(Arow), 64'(r.row));
               check("ain", Ain, r.data);
               check("ready_in_commit", 64'(wr_ready), 64'd0);
            end
         end
         if (en) en_run++;
         if (done) begin
            done_cnt++;
            if (exp_runs.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("drain_len", 64'(en_run), 64'(exp_runs.pop_front()));
            check("busy_at_done", 64'(busy), 64'd0);
            en_run = 0;
         end
      end
   end

   // mode 0: continuous valid, 1: valid toggles each cycle, 2: random valid
   task automatic load_matrix(input int mode, input bit ramp, input bit inj_start);
      int  idx;
      int  cyc;
      bit  hs;
      bit  tog;
      for (int i = 0; i < NW; i++)
         words[i] = ramp ? {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} : $urandom;
      push_rows();
      load = 1'b1;
      tick();
      load = 1'b0;
      idx = 0;
      cyc = 0;
      tog = 1'b1;
      while (idx < NW && cyc < 400) begin
         wr_data = words[idx];
         case (mode)
            0: wr_valid = 1'b1;
            1: begin wr_valid = tog; tog = !tog; end
            default: wr_valid = 1'($urandom_range(0, 1));
         endcase
         start = inj_start && (idx == 5);
         hs = wr_valid && wr_ready;
         tick();
         if (hs) idx++;
         cyc++;
      end
      wr_valid = 1'b0;
      start = 1'b0;
      check("words_accepted", 64'(idx), 64'(NW));
      cyc = 0;
      while (!loaded && cyc < 10) begin
         tick();
         cyc++;
      end
      check("loaded", 64'(loaded), 64'd1);
   endtask

   task automatic run_stream(input bit inj_load);
      int c;
      int d0;
      exp_runs.push_back(DRAIN);
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      c = 0;
      while (done_cnt == d0 && c < 60) begin
         load = inj_load && (c == 5);
         tick();
         c++;
      end
      load = 1'b0;
      check("done_seen", 64'(done_cnt - d0), 64'd1);
      tick();
      check("idle_after_done", 64'(busy), 64'd0);
      check("loaded_after_done", 64'(loaded), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0;
      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_wr_ready", 64'(wr_ready), 64'd0);
      check("rst_wren", 64'(WrEn), 64'd0);
      check("rst_en", 64'(en), 64'd0);
      check("rst_loaded", 64'(loaded), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ain", Ain, 64'd0);
      rst_n = 1'b1;
      tick();

      // start in IDLE is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_idle", 64'(busy), 64'd0);

      // Ramp matrix, continuous valid, then a normal drain
      load_matrix(0, 1'b1, 1'b0);
      run_stream(1'b0);

      // Same ramp with valid toggling every cycle
      load_matrix(1, 1'b1, 1'b0);
      run_stream(1'b0);

      // start during LOAD and load during STREAM have no effect
      load_matrix(0, 1'b0, 1'b1);
      run_stream(1'b1);

      // Reset in stream cycle 10: enable drops, no done, then reload works
      load_matrix(2, 1'b0, 1'b0);
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("en_before_rst", 64'(en), 64'd1);
      rst_n = 1'b0;
      tick();
      check("en_after_rst", 64'(en), 64'd0);
      check("busy_after_rst", 64'(busy), 64'd0);
      check("wren_after_rst", 64'(WrEn), 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      check("no_done_after_rst", 64'(done_cnt - d0), 64'd0);

      // Random matrices with random valid gaps
      for (int m = 0; m < 3; m++) begin
         load_matrix(2, 1'b0, 1'b0);
         run_stream(1'b0);
      end

      check("rows_drained", 64'(exp_rows.size()), 64'd0);
      check("runs_drained", 64'(exp_runs.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
